pixel_stream_packer: RTL and testbench

PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

---
 rtl/pixel_stream_packer.sv | 145 ++++++++++++++
 tb/tb_pixel_stream_packer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - packs 24-bit RGB pixels into 32-bit words with a frame header
module pixel_stream_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in_width,
  input  logic [15:0] in_height,
  input  logic [7:0]  in_pixel_r,
  input  logic [7:0]  in_pixel_g,
  input  logic [7:0]  in_pixel_b,
  input  logic        in_valid,
  output logic        upstream_stall,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        downstream_stall,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] pix_cnt, pix_cnt_n;
  logic [23:0] res_buf, res_buf_n;
  logic [1:0]  res_cnt, res_cnt_n;
  logic [31:0] out_data_n;
  logic        out_valid_n;
  logic        frame_done_n;

  logic        xfer;
  logic        accept;
  logic [47:0] packed_w;

  // Handshake qualifiers; pixels are only taken in DATA while the output register can move
  always_comb begin
    upstream_stall = (state != S_DATA) || (out_valid && downstream_stall);
    xfer           = out_valid && !downstream_stall;
    accept         = in_valid && !upstream_stall;
  end

  // Append the incoming R,G,B bytes above the residual bytes, little-endian
  always_comb begin
    packed_w = {24'd0, res_buf}
             | ({24'd0, in_pixel_b, in_pixel_g, in_pixel_r} << {res_cnt, 3'b000});
  end

  // Next-state and next-output logic; the output word is held unless it transfers
  always_comb begin
    state_n      = state;
    pix_cnt_n    = pix_cnt;
    res_buf_n    = res_buf;
    res_cnt_n    = res_cnt;
    out_data_n   = out_data;
    out_valid_n  = out_valid && !xfer;
    frame_done_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          out_data_n  = {in_height, in_width};
          out_valid_n = 1'b1;
          pix_cnt_n   = {16'd0, in_width} * {16'd0, in_height};
          res_buf_n   = 24'd0;
          res_cnt_n   = 2'd0;
          state_n     = S_HEADER;
        end
      end

      S_HEADER: begin
        if (xfer) begin
          state_n = (pix_cnt == 32'd0) ? S_DONE : S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          pix_cnt_n = pix_cnt - 32'd1;
          if (res_cnt != 2'd0) begin
            // residual + 3 new bytes reaches a full word; keep the bytes above it
            out_data_n  = packed_w[31:0];
            out_valid_n = 1'b1;
            res_buf_n   = {8'd0, packed_w[47:32]};
            res_cnt_n   = res_cnt - 2'd1;
          end else begin
            res_buf_n = packed_w[23:0];
            res_cnt_n = 2'd3;
          end
          if (pix_cnt == 32'd1) begin
            state_n = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        if (!out_valid || xfer) begin
          if (res_cnt != 2'd0) begin
            // residual is already zero in its unused high bytes
            out_data_n  = {8'd0, res_buf};
            out_valid_n = 1'b1;
          end
          res_buf_n = 24'd0;
          res_cnt_n = 2'd0;
          state_n   = S_DONE;
        end
      end

      S_DONE: begin
        if (!out_valid) begin
          frame_done_n = 1'b1;
          state_n      = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a mid-frame reset aborts cleanly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pix_cnt    <= 32'd0;
      res_buf    <= 24'd0;
      res_cnt    <= 2'd0;
      out_data   <= 32'd0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_cnt_n;
      res_buf    <= res_buf_n;
      res_cnt    <= res_cnt_n;
      out_data   <= out_data_n;
      out_valid  <= out_valid_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb/tb_pixel_stream_packer.sv - directed self-checking bench for pixel_stream_packer
module tb_pixel_stream_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_width;
  logic [15:0] in_height;
  logic [7:0]  in_pixel_r;
  logic [7:0]  in_pixel_g;
  logic [7:0]  in_pixel_b;
  logic        in_valid;
  logic        upstream_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        downstream_stall;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int accepts = 0;
  int stall_mode = 0;
  int scnt = 0;

  logic [31:0] words[$];
  logic [31:0] exp_q[$];
  logic [7:0]  pix_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_data = 32'd0;

  pixel_stream_packer dut (
    .clock            (clock),
    .reset            (reset),
    .in_width         (in_width),
    .in_height        (in_height),
    .in_pixel_r       (in_pixel_r),
    .in_pixel_g       (in_pixel_g),
    .in_pixel_b       (in_pixel_b),
    .in_valid         (in_valid),
    .upstream_stall   (upstream_stall),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .downstream_stall (downstream_stall),
    .frame_done       (frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: capture transferred words, accepted pixels, done pulses, and hold stability
  always @(negedge clock) begin
    if (hold_pend) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, hold_data);
    end
    hold_pend = out_valid && downstream_stall && !reset;
    hold_data = out_data;
    if (out_valid && !downstream_stall) words.push_back(out_data);
    if (in_valid && !upstream_stall) accepts++;
    if (frame_done) done_cnt++;
  end

  // Consumer back-pressure generator
  initial begin
    downstream_stall = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (stall_mode)
        1: begin
          if (out_valid && scnt < 3) begin
            downstream_stall = 1'b1;
            scnt++;
          end else begin
            downstream_stall = 1'b0;
            scnt = 0;
          end
        end
        2: downstream_stall = ($urandom_range(0, 2) == 0);
        default: downstream_stall = 1'b0;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic add_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pix_q.push_back(r);
    pix_q.push_back(g);
    pix_q.push_back(b);
  endtask

  task automatic build_expected(input logic [15:0] w, input logic [15:0] h);
    logic [31:0] word;
    exp_q.delete();
    exp_q.push_back({h, w});
    for (int i = 0; i < pix_q.size(); i += 4) begin
      word = 32'd0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < pix_q.size()) word[8*j +: 8] = pix_q[i+j];
      end
      exp_q.push_back(word);
    end
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
    @(posedge clock);
    #1;
    in_width  = w;
    in_height = h;
    if (pix_q.size() >= 3) begin
      in_pixel_r = pix_q[0];
      in_pixel_g = pix_q[1];
      in_pixel_b = pix_q[2];
    end else begin
      in_pixel_r = 8'd0;
      in_pixel_g = 8'd0;
      in_pixel_b = 8'd0;
    end
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_width  = 16'hFFFF;
    in_height = 16'hFFFF;
    if (int'(w) * int'(h) == 0) in_valid = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit rnd);
    int gap;
    int t;
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (rnd && i > 0) begin
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) begin
            @(posedge clock);
            #1;
          end
        end
      end
      in_pixel_r = pix_q[3*i];
      in_pixel_g = pix_q[3*i+1];
      in_pixel_b = pix_q[3*i+2];
      in_valid   = 1'b1;
      t  = 0;
      ok = 1'b0;
      while (!ok && t < 500) begin
        @(negedge clock);
        if (!upstream_stall) ok = 1'b1;
        else t++;
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input int mode);
    int npix;
    int base;
    int t;
    npix = int'(w) * int'(h);
    stall_mode = mode;
    words.delete();
    accepts = 0;
    base = done_cnt;
    start_frame(w, h);
    drive_pixels(npix, mode == 2);
    t = 0;
    while (done_cnt == base && t < 3000) begin
      @(posedge clock);
      t++;
    end
    repeat (5) @(posedge clock);
    check("frame_done_pulses", done_cnt - base, 32'd1);
    check("accepts", accepts, npix);
    check("word_count", words.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < words.size()) check($sformatf("word%0d", i), words[i], exp_q[i]);
    end
    stall_mode = 0;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_width   = 16'd0;
    in_height  = 16'd0;
    in_pixel_r = 8'd0;
    in_pixel_g = 8'd0;
    in_pixel_b = 8'd0;
    in_valid   = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_upstream_stall", {31'd0, upstream_stall}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 2x2 frame, no back-pressure
    pix_q.delete();
    add_pix(8'h01, 8'h02, 8'h03);
    add_pix(8'h04, 8'h05, 8'h06);
    add_pix(8'h07, 8'h08, 8'h09);
    add_pix(8'h0A, 8'h0B, 8'h0C);
    exp_q.delete();
    exp_q.push_back(32'h00020002);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    run_frame(16'd2, 16'd2, 0);

    // same frame with 3-cycle stall on every word
    run_frame(16'd2, 16'd2, 1);

    // 1x1 frame, zero-padded tail word
    pix_q.delete();
    add_pix(8'hAA, 8'hBB, 8'hCC);
    exp_q.delete();
    exp_q.push_back(32'h00010001);
    exp_q.push_back(32'h00CCBBAA);
    run_frame(16'd1, 16'd1, 0);

    // empty frame: header only
    pix_q.delete();
    exp_q.delete();
    exp_q.push_back(32'h00050000);
    run_frame(16'd0, 16'd5, 0);

    // 4x4 frame aborted by reset after 5 pixels
    pix_q.delete();
    for (int i = 0; i < 16; i++) add_pix(8'(3*i+1), 8'(3*i+2), 8'(3*i+3));
    stall_mode = 0;
    start_frame(16'd4, 16'd4);
    drive_pixels(5, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_frame_done", {31'd0, frame_done}, 32'd0);
    check("arst_upstream_stall", {31'd0, upstream_stall}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    pix_q.delete();
    add_pix(8'hAA, 8'hBB, 8'hCC);
    exp_q.delete();
    exp_q.push_back(32'h00010001);
    exp_q.push_back(32'h00CCBBAA);
    run_frame(16'd1, 16'd1, 0);

    // 7x3 frame with random pixel gaps and back-pressure against the packing model
    pix_q.delete();
    for (int i = 0; i < 21; i++) add_pix(8'($urandom), 8'($urandom), 8'($urandom));
    build_expected(16'd7, 16'd3);
    run_frame(16'd7, 16'd3, 2);
    check("random_word_total", words.size(), 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
